// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and zeroed control on empty.
// STAGE_SKID_EN selects a 2-entry skid buffer with registered in_ready; default is a single register.
module pipe_stage_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_vld_q,  main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              accept;
  logic              release_head;

  assign release_head = main_vld_q & out_ready;
  assign accept       = in_valid & in_ready;

`ifdef STAGE_SKID_EN
  logic              skid_vld_q,  skid_vld_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // in_ready depends only on state, so out_ready never reaches upstream combinationally.
  assign in_ready  = ~skid_vld_q;
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
      skid_vld_d  = 1'b0;
      skid_ctrl_d = '0;
    end else if (skid_vld_q) begin
      if (release_head) begin
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end
    end else if (!main_vld_q || release_head) begin
      main_vld_d = accept;
      if (accept) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign in_ready  = out_ready | ~main_vld_q;
  assign occupancy = {1'b0, main_vld_q};

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    if (flush) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
    end else if (accept) begin
      main_vld_d  = 1'b1;
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (release_head) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  // Bubbles never present live control bits downstream.
  assign out_valid = main_vld_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_vld_q}};
  assign out_data  = main_data_q;

endmodule
